// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if: one requester's request and read-response channels.
interface bram_port_arbiter_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 15
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one BRAM port between two requesters with credit-limited read responses.
module bram_port_arbiter #(
    parameter int DATA_W    = 256,
    parameter int ADDR_W    = 15,
    parameter int DEPTH     = 20480,
    parameter int RSP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    bram_port_arbiter_if.slave  req0_if,
    bram_port_arbiter_if.slave  req1_if,
    output logic                bram_en_o,
    output logic                bram_we_o,
    output logic [ADDR_W-1:0]   bram_addr_o,
    output logic [DATA_W-1:0]   bram_wdata_o,
    input  logic [DATA_W-1:0]   bram_rdata_i,
    output logic                err_addr_o
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    logic [1:0]        valid, write, rsp_ready, elig, grant, push, pop, rsp_valid;
    logic [ADDR_W-1:0] addr [2];
    logic [DATA_W-1:0] wdata [2];
    logic [DATA_W-1:0] rsp_data [2];
    logic [DATA_W-1:0] fill_data;
    logic              sel, accept, oor;
    logic              last_grant_q, last_grant_d;
    logic              s1_valid_q, s1_id_q, s1_oor_q, err_q;
    assign valid     = {req1_if.req_valid, req0_if.req_valid};
    assign write     = {req1_if.req_write, req0_if.req_write};
    assign rsp_ready = {req1_if.rsp_ready, req0_if.rsp_ready};
    assign addr[0]   = req0_if.req_addr;
    assign addr[1]   = req1_if.req_addr;
    assign wdata[0]  = req0_if.req_wdata;
    assign wdata[1]  = req1_if.req_wdata;
    // On a tie the requester that did not win last time goes first.
    assign grant[0] = !rst && elig[0] && (!elig[1] || last_grant_q);
    assign grant[1] = !rst && elig[1] && !grant[0];
    always_comb begin
        sel          = grant[1];
        accept       = |grant;
        oor          = 32'(addr[sel]) >= 32'(DEPTH);
        last_grant_d = accept ? sel : last_grant_q;
        bram_en_o    = accept && !oor;
        bram_we_o    = bram_en_o && write[sel];
        bram_addr_o  = addr[sel];
        bram_wdata_o = wdata[sel];
        fill_data    = s1_oor_q ? '0 : bram_rdata_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_oor_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= accept && !write[sel];
            s1_id_q      <= sel;
            s1_oor_q     <= oor;
            err_q        <= accept && oor;
        end
    end
    assign err_addr_o = err_q;
    for (genvar n = 0; n < 2; n++) begin : g_rsp
        logic [CW-1:0]     cnt_q, cnt_d;
        logic [PW-1:0]     wp_q, rp_q;
        logic [CW:0]       used;
        logic [DATA_W-1:0] mem_q [RSP_DEPTH];
        // The single pipeline stage holding a read for this requester counts as one outstanding credit.
        assign push[n]      = s1_valid_q && s1_id_q == 1'(n);
        assign pop[n]       = rsp_valid[n] && rsp_ready[n];
        assign used         = {1'b0, cnt_q} + {{CW{1'b0}}, push[n]};
        assign elig[n]      = valid[n] && (write[n] || used < (CW+1)'(RSP_DEPTH));
        assign cnt_d        = cnt_q + CW'(push[n]) - CW'(pop[n]);
        assign rsp_valid[n] = cnt_q != '0;
        assign rsp_data[n]  = rsp_valid[n] ? mem_q[rp_q] : '0;
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                wp_q  <= '0;
                rp_q  <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (push[n]) wp_q <= (wp_q == PW'(RSP_DEPTH - 1)) ? '0 : wp_q + 1'b1;
                if (pop[n])  rp_q <= (rp_q == PW'(RSP_DEPTH - 1)) ? '0 : rp_q + 1'b1;
            end
        end
        always_ff @(posedge clk) begin
            if (push[n]) mem_q[wp_q] <= fill_data;
        end
        overflow_a: assert property (@(posedge clk) disable iff (rst)
            !(push[n] && !pop[n] && cnt_q == CW'(RSP_DEPTH)));
    end
    assign req0_if.req_ready = grant[0];
    assign req1_if.req_ready = grant[1];
    assign req0_if.rsp_valid = rsp_valid[0];
    assign req1_if.rsp_valid = rsp_valid[1];
    assign req0_if.rsp_data  = rsp_data[0];
    assign req1_if.rsp_data  = rsp_data[1];
endmodule
